// File: rtl/lif_neuron_delayed_if.sv
// -----------------------------------------------------------------------------
// lif_neuron_delayed_if
// Bundle of all non-clock, non-reset signals of one delayed LIF neuron.
//
// Timing contract: the neuron has no valid/ready handshake. `enable` is a
// timestep strobe. The neuron samples every input on each rising clk edge
// where enable=1. It holds its state on edges where enable=0. Outputs are
// registered and can be read at any time.
//
//   master : driver side (stimulus / upstream layer). It drives the inputs
//            and reads the outputs.
//   slave  : the neuron itself.
//
//   enable                 timestep strobe
//   input_spikes[M]        spike vector for the current timestep
//   weights[M*NBITS]       unsigned weight of synapse i at [i*NBITS +: NBITS]
//   delays[M*DBITS]        delay of synapse i at [i*DBITS +: DBITS]
//   threshold/decay/refractory_period  neuron configuration, NBITS each
//   membrane_potential_out registered membrane potential
//   refractory_active      refractory counter non-zero
//   spike_out              registered output spike
// -----------------------------------------------------------------------------
interface lif_neuron_delayed_if #(
  parameter int M     = 8,
  parameter int NBITS = 4,
  parameter int DBITS = 2
);
  logic                 enable;
  logic [M-1:0]         input_spikes;
  logic [M*NBITS-1:0]   weights;
  logic [M*DBITS-1:0]   delays;
  logic [NBITS-1:0]     threshold;
  logic [NBITS-1:0]     decay;
  logic [NBITS-1:0]     refractory_period;
  logic [NBITS-1:0]     membrane_potential_out;
  logic                 refractory_active;
  logic                 spike_out;

  modport master (
    output enable, input_spikes, weights, delays,
           threshold, decay, refractory_period,
    input  membrane_potential_out, refractory_active, spike_out
  );

  modport slave (
    input  enable, input_spikes, weights, delays,
           threshold, decay, refractory_period,
    output membrane_potential_out, refractory_active, spike_out
  );
endinterface

// File: rtl/lif_neuron_delayed.sv
// -----------------------------------------------------------------------------
// lif_neuron_delayed
// Leaky integrate-and-fire neuron with a programmable axonal delay per synapse.
// Each synapse keeps a DMAX-deep history of its past enabled-step inputs. The
// delay of the synapse selects which history tap, or the live input, feeds
// the weighted sum. The membrane leaks by `decay`, integrates the sum with
// saturation, and fires when it reaches `threshold`. After a spike the
// neuron stays silent for `refractory_period` enabled steps.
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high; has priority over bus.enable
//   bus    lif_neuron_delayed_if.slave (inputs, config and registered outputs)
// -----------------------------------------------------------------------------
module lif_neuron_delayed #(
  parameter int M     = 8,
  parameter int NBITS = 4,
  parameter int DBITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  lif_neuron_delayed_if.slave   bus
);

  localparam int DMAX = (1 << DBITS) - 1;
  // Wide enough that M full-scale weights plus a full-scale membrane never wrap.
  localparam int IW   = NBITS + $clog2(M) + 1;
  localparam logic [NBITS-1:0] VMAX = '1;

  // r_hist[i][k] = input spike of synapse i from k+1 enabled steps ago
  logic [M-1:0][DMAX-1:0] r_hist;
  logic [NBITS-1:0]       r_mem;
  logic [NBITS-1:0]       r_refr;
  logic                   r_spike;

  logic [M-1:0]           w_ds;
  logic [IW-1:0]          w_current;
  logic [NBITS-1:0]       w_leak;
  logic [IW-1:0]          w_sum;
  logic [NBITS-1:0]       w_v;

  // Delayed spike selection. Delay 0 bypasses the history and uses the live
  // input. A delay change takes effect at once against the stored history.
  always_comb begin
    w_ds = '0;
    for (int i = 0; i < M; i++) begin
      if (bus.delays[i*DBITS +: DBITS] == '0) begin
        w_ds[i] = bus.input_spikes[i];
      end else begin
        w_ds[i] = r_hist[i][bus.delays[i*DBITS +: DBITS] - DBITS'(1)];
      end
    end
  end

  // Synaptic current: sum of the weights of all synapses whose delayed spike is set.
  always_comb begin
    w_current = '0;
    for (int i = 0; i < M; i++) begin
      if (w_ds[i]) begin
        w_current = w_current + IW'(bus.weights[i*NBITS +: NBITS]);
      end
    end
  end

  // Leak floors at zero. The integrate step then saturates at VMAX.
  always_comb begin
    w_leak = (r_mem > bus.decay) ? (r_mem - bus.decay) : '0;
    w_sum  = {{(IW-NBITS){1'b0}}, w_leak} + w_current;
    w_v    = (w_sum > {{(IW-NBITS){1'b0}}, VMAX}) ? VMAX : w_sum[NBITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist  <= '0;
      r_mem   <= '0;
      r_refr  <= '0;
      r_spike <= 1'b0;
    end else begin
      // A spike lasts exactly one clk cycle, even when the next edge is not enabled.
      r_spike <= 1'b0;
      if (bus.enable) begin
        for (int i = 0; i < M; i++) begin
          r_hist[i][0] <= bus.input_spikes[i];
          for (int k = 1; k < DMAX; k++) begin
            r_hist[i][k] <= r_hist[i][k-1];
          end
        end
        if (r_refr != '0) begin
          // Refractory: the current is dropped, but the history above still shifts.
          r_refr <= r_refr - NBITS'(1);
          r_mem  <= '0;
        end else if (w_v >= bus.threshold) begin
          r_spike <= 1'b1;
          r_mem   <= '0;
          r_refr  <= bus.refractory_period;
        end else begin
          r_mem   <= w_v;
        end
      end
    end
  end

  assign bus.membrane_potential_out = r_mem;
  assign bus.refractory_active      = (r_refr != '0);
  assign bus.spike_out              = r_spike;

endmodule
